// File: rtl/counter_ram_arbiter.sv
// counter_ram_arbiter: round-robin access to a shared counter RAM plus a sweep-clear sequencer
module counter_ram_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int BITS_DIRECT = 6,
  parameter int SIZE_COUNTER = 4,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           gen_reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [2*NUM_REQ-1:0]           req_op,
  input  logic [BITS_DIRECT*NUM_REQ-1:0] req_addr,
  output logic [NUM_REQ-1:0]             gnt,
  input  logic                           flush_start,
  output logic                           busy,
  output logic                           rd_valid,
  output logic [IDW-1:0]                 rd_id,
  output logic [SIZE_COUNTER-1:0]        rd_data,
  output logic                           ram_we,
  output logic [BITS_DIRECT-1:0]         ram_addr,
  output logic                           ram_read,
  output logic                           ram_clr,
  input  logic [SIZE_COUNTER-1:0]        ram_dout
);
  typedef enum logic [1:0] {S_IDLE, S_SERVE, S_FLUSH} state_t;
  state_t                 r_state;
  logic [IDW-1:0]         r_ptr;
  logic [IDW-1:0]         r_cmd_id;
  logic [IDW-1:0]         r_p1_id;
  logic                   r_p1;
  logic [BITS_DIRECT-1:0] r_flush_cnt;
  logic                   w_hit;
  logic [IDW-1:0]         w_win;
  logic [IDW-1:0]         w_ptr_nxt;
  logic [1:0]             w_op;
  logic [BITS_DIRECT-1:0] w_addr;
  int                     w_j;
  // first active requester at or after the pointer, and its op/address
  always_comb begin
    w_hit = 1'b0;
    w_win = '0;
    w_j = 0;
    w_op = 2'b11;
    w_addr = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_j = int'(r_ptr) + k;
      w_j = (w_j >= NUM_REQ) ? w_j - NUM_REQ : w_j;
      if (!w_hit && req[IDW'(w_j)]) begin
        w_hit = 1'b1;
        w_win = IDW'(w_j);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == IDW'(i)) begin
        w_op = req_op[2*i +: 2];
        w_addr = req_addr[BITS_DIRECT*i +: BITS_DIRECT];
      end
    end
    w_ptr_nxt = (w_win == IDW'(NUM_REQ-1)) ? '0 : w_win + 1'b1;
  end
  // control FSM: grants, flush sweep and the two-stage read-return pipeline
  always_ff @(posedge clk or posedge gen_reset) begin
    if (gen_reset) begin
      r_state <= S_IDLE;
      r_ptr <= '0;
      r_cmd_id <= '0;
      r_p1 <= 1'b0;
      r_p1_id <= '0;
      r_flush_cnt <= '0;
      gnt <= '0;
      busy <= 1'b0;
      rd_valid <= 1'b0;
      rd_id <= '0;
      rd_data <= '0;
      ram_we <= 1'b0;
      ram_addr <= '0;
      ram_read <= 1'b0;
      ram_clr <= 1'b0;
    end else begin
      gnt <= '0;
      ram_we <= 1'b0;
      ram_read <= 1'b0;
      ram_clr <= 1'b0;
      ram_addr <= '0;
      r_p1 <= ram_read;
      r_p1_id <= r_cmd_id;
      rd_valid <= r_p1;
      rd_id <= r_p1 ? r_p1_id : '0;
      rd_data <= r_p1 ? ram_dout : '0;
      if (r_state == S_FLUSH) begin
        if (r_flush_cnt == '1) begin
          r_state <= S_IDLE;
          busy <= 1'b0;
          r_flush_cnt <= '0;
        end else begin
          r_flush_cnt <= r_flush_cnt + 1'b1;
          ram_clr <= 1'b1;
          ram_addr <= r_flush_cnt + 1'b1;
        end
      end else if (flush_start) begin
        r_state <= S_FLUSH;
        busy <= 1'b1;
        ram_clr <= 1'b1;
        r_flush_cnt <= '0;
      end else if (w_hit) begin
        r_state <= S_SERVE;
        gnt <= NUM_REQ'(1) << w_win;
        ram_addr <= w_addr;
        ram_we <= (w_op == 2'b00);
        ram_read <= (w_op == 2'b01);
        ram_clr <= (w_op == 2'b10);
        r_cmd_id <= w_win;
        r_ptr <= w_ptr_nxt;
      end else begin
        r_state <= S_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_counter_ram_arbiter.sv
// tb_counter_ram_arbiter: vector table, directed corner sequences and a random run against a shadow model
module tb_counter_ram_arbiter;
  localparam int N = 4;
  localparam int BD = 6;
  localparam int SC = 4;
  logic clk = 1'b0;
  logic gen_reset = 1'b1;
  logic flush_start = 1'b0;
  logic [N-1:0] req = '0;
  logic [2*N-1:0] req_op = '0;
  logic [BD*N-1:0] req_addr = '0;
  logic [N-1:0] gnt;
  logic busy, rd_valid, ram_we, ram_read, ram_clr;
  logic [1:0] rd_id;
  logic [SC-1:0] rd_data;
  logic [SC-1:0] ram_dout = '0;
  logic [BD-1:0] ram_addr;
  logic [SC-1:0] ram_mem [2**BD] = '{default: '0};
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [N-1:0] req;
    logic [2*N-1:0] op;
    logic [BD*N-1:0] addr;
    logic [N-1:0] gnt;
    logic we, rd, clr;
    logic [BD-1:0] a;
  } vec_t;
  vec_t tv[8];

  typedef struct {int due; int id; int data;} rd_t;
  rd_t rq[$];
  int mmem[2**BD];
  int mptr;
  logic pv[N];
  int po[N];
  int pa[N];

  always #5 clk = ~clk;

  counter_ram_arbiter #(.NUM_REQ(N), .BITS_DIRECT(BD), .SIZE_COUNTER(SC)) dut (
    .clk(clk), .gen_reset(gen_reset), .req(req), .req_op(req_op), .req_addr(req_addr),
    .gnt(gnt), .flush_start(flush_start), .busy(busy), .rd_valid(rd_valid), .rd_id(rd_id),
    .rd_data(rd_data), .ram_we(ram_we), .ram_addr(ram_addr), .ram_read(ram_read),
    .ram_clr(ram_clr), .ram_dout(ram_dout)
  );

  // counter RAM: acts one edge after the command cycle, registered count_out
  always @(posedge clk) begin
    if (ram_clr) ram_mem[ram_addr] <= '0;
    else if (ram_we) ram_mem[ram_addr] <= ram_mem[ram_addr] + 1'b1;
    if (ram_read) ram_dout <= ram_mem[ram_addr];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_rd(input int t);
    logic ev;
    ev = (rq.size() > 0) && (rq[0].due == t);
    check("rnd_rd_valid", 32'(rd_valid), 32'(ev));
    if (ev) begin
      check("rnd_rd_id", 32'(rd_id), rq[0].id);
      check("rnd_rd_data", 32'(rd_data), rq[0].data);
      void'(rq.pop_front());
    end
  endtask

  task automatic check_no_rd(input string nm, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      tick;
      check(nm, 32'(rd_valid), 0);
    end
  endtask

  initial begin
    int k, n, w, ea;
    logic [N-1:0] eg;
    logic ewe, erd, eclr;
    tv[0] = '{4'b0001, 8'b00_00_00_00, {6'd0, 6'd0, 6'd0, 6'd10}, 4'b0001, 1'b1, 1'b0, 1'b0, 6'd10};
    tv[1] = '{4'b0011, 8'b00_00_10_00, {6'd0, 6'd0, 6'd11, 6'd10}, 4'b0010, 1'b0, 1'b0, 1'b1, 6'd11};
    tv[2] = '{4'b0001, 8'b00_00_00_00, {6'd0, 6'd0, 6'd0, 6'd10}, 4'b0001, 1'b1, 1'b0, 1'b0, 6'd10};
    tv[3] = '{4'b1000, 8'b01_00_00_00, {6'd12, 6'd0, 6'd0, 6'd0}, 4'b1000, 1'b0, 1'b1, 1'b0, 6'd12};
    tv[4] = '{4'b1001, 8'b01_00_00_11, {6'd12, 6'd0, 6'd0, 6'd13}, 4'b0001, 1'b0, 1'b0, 1'b0, 6'd13};
    tv[5] = '{4'b0000, 8'b00_00_00_00, {6'd0, 6'd0, 6'd0, 6'd0}, 4'b0000, 1'b0, 1'b0, 1'b0, 6'd0};
    tv[6] = '{4'b1100, 8'b01_00_00_00, {6'd15, 6'd14, 6'd0, 6'd0}, 4'b0100, 1'b1, 1'b0, 1'b0, 6'd14};
    tv[7] = '{4'b1100, 8'b01_00_00_00, {6'd15, 6'd14, 6'd0, 6'd0}, 4'b1000, 1'b0, 1'b1, 1'b0, 6'd15};

    tick;
    tick;
    check("reset_outputs", 32'({gnt, busy, rd_valid, rd_id, rd_data, ram_we, ram_addr, ram_read, ram_clr}), 0);
    gen_reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      req = tv[i].req;
      req_op = tv[i].op;
      req_addr = tv[i].addr;
      tick;
      check("vec_gnt", 32'(gnt), 32'(tv[i].gnt));
      check("vec_we", 32'(ram_we), 32'(tv[i].we));
      check("vec_read", 32'(ram_read), 32'(tv[i].rd));
      check("vec_clr", 32'(ram_clr), 32'(tv[i].clr));
      check("vec_addr", 32'(ram_addr), 32'(tv[i].a));
    end
    req = '0;
    tick; tick; tick;

    req = 4'b0100;
    req_op = '0;
    req_addr = {6'd0, 6'd5, 6'd0, 6'd0};
    for (int i = 0; i < 3; i++) begin
      tick;
      check("inc5_gnt", 32'(gnt), 32'b0100);
      check("inc5_we", 32'({ram_we, ram_read, ram_clr}), 32'b100);
      check("inc5_addr", 32'(ram_addr), 5);
    end
    req = 4'b0001;
    req_op = 8'b00_00_00_01;
    req_addr = {6'd0, 6'd0, 6'd0, 6'd5};
    tick;
    check("rd5_gnt", 32'(gnt), 32'b0001);
    check("rd5_read", 32'(ram_read), 1);
    req = '0;
    tick;
    check("rd5_early", 32'(rd_valid), 0);
    tick;
    check("rd5_valid", 32'(rd_valid), 1);
    check("rd5_id", 32'(rd_id), 0);
    check("rd5_data", 32'(rd_data), 3);
    tick;
    check("rd5_pulse", 32'(rd_valid), 0);

    gen_reset = 1'b1;
    tick;
    gen_reset = 1'b0;
    req = 4'b1111;
    req_op = 8'b01_01_01_01;
    req_addr = {6'd23, 6'd22, 6'd21, 6'd20};
    for (int i = 0; i < 7; i++) begin
      if (i == 5) req = '0;
      tick;
      check("rr_gnt", 32'(gnt), (i < 5) ? (32'd1 << (i % 4)) : 0);
      check("rr_rd_valid", 32'(rd_valid), 32'(i >= 2));
      if (i >= 2) begin
        check("rr_rd_id", 32'(rd_id), (i - 2) % 4);
        check("rr_rd_data", 32'(rd_data), 0);
      end
    end

    req = 4'b0010;
    req_op = '0;
    req_addr = {6'd0, 6'd0, 6'd63, 6'd0};
    n = 0;
    for (int i = 0; i < 17; i++) begin
      tick;
      if (gnt == 4'b0010 && ram_we && ram_addr == 6'd63) n++;
    end
    check("wrap_inc_count", n, 17);
    req_op = 8'b00_00_01_00;
    tick;
    check("wrap_read_cmd", 32'({gnt, ram_read}), 32'b00101);
    req = '0;
    tick;
    tick;
    check("wrap_rd_valid", 32'(rd_valid), 1);
    check("wrap_rd_id", 32'(rd_id), 1);
    check("wrap_rd_data", 32'(rd_data), 1);

    flush_start = 1'b1;
    req = 4'b1000;
    req_op = 8'b01_00_00_00;
    req_addr = {6'd5, 6'd0, 6'd0, 6'd0};
    tick;
    flush_start = 1'b0;
    k = 0;
    while (busy && k < 100) begin
      check("flush_clr", 32'(ram_clr), 1);
      check("flush_addr", 32'(ram_addr), k);
      check("flush_no_gnt", 32'(gnt), 0);
      flush_start = (k == 10);
      tick;
      k++;
    end
    flush_start = 1'b0;
    check("flush_len", k, 64);
    check("flush_idle_gnt", 32'({gnt, ram_clr}), 0);
    tick;
    check("flush_resume_gnt", 32'(gnt), 32'b1000);
    check("flush_resume_read", 32'({ram_read, ram_addr}), {26'd0, 1'b1, 6'd5});
    req = '0;
    tick;
    tick;
    check("flush_rd_valid", 32'(rd_valid), 1);
    check("flush_rd_id", 32'(rd_id), 3);
    check("flush_rd_data", 32'(rd_data), 0);

    req = 4'b0001;
    req_op = 8'b00_00_00_01;
    req_addr = {6'd0, 6'd0, 6'd0, 6'd63};
    tick;
    check("rst_rd_gnt", 32'(gnt), 32'b0001);
    req = '0;
    #2;
    gen_reset = 1'b1;
    #1;
    check("rst_mid_outputs", 32'({gnt, busy, rd_valid, rd_id, rd_data, ram_we, ram_addr, ram_read, ram_clr}), 0);
    tick;
    gen_reset = 1'b0;
    check_no_rd("rst_no_rd", 3);

    req = 4'b0010;
    req_op = 8'b00_00_11_00;
    req_addr = {6'd0, 6'd0, 6'd7, 6'd0};
    tick;
    check("rsv_gnt", 32'(gnt), 32'b0010);
    check("rsv_pins", 32'({ram_we, ram_read, ram_clr}), 0);
    req = '0;
    check_no_rd("rsv_no_rd", 3);

    flush_start = 1'b1;
    tick;
    flush_start = 1'b0;
    k = 0;
    while (busy && k < 100) begin
      tick;
      k++;
    end
    check("pre_rand_flush_done", 32'(busy), 0);
    gen_reset = 1'b1;
    tick;
    gen_reset = 1'b0;
    mptr = 0;
    for (int i = 0; i < 2**BD; i++) mmem[i] = 0;
    for (int i = 0; i < N; i++) pv[i] = 1'b0;

    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && $urandom_range(0, 1) == 0) begin
          pv[i] = 1'b1;
          po[i] = int'($urandom_range(0, 3));
          pa[i] = int'($urandom_range(0, 7));
        end
        req[i] = pv[i];
        req_op[2*i +: 2] = 2'(po[i]);
        req_addr[BD*i +: BD] = BD'(pa[i]);
      end
      w = -1;
      for (int j = 0; j < N; j++)
        if (w < 0 && pv[(mptr + j) % N]) w = (mptr + j) % N;
      eg = '0;
      ewe = 1'b0;
      erd = 1'b0;
      eclr = 1'b0;
      ea = 0;
      if (w >= 0) begin
        eg = N'(1) << w;
        ea = pa[w];
        if (po[w] == 0) begin
          ewe = 1'b1;
          mmem[ea] = (mmem[ea] + 1) % (2**SC);
        end else if (po[w] == 1) begin
          erd = 1'b1;
          rq.push_back('{t + 2, w, mmem[ea]});
        end else if (po[w] == 2) begin
          eclr = 1'b1;
          mmem[ea] = 0;
        end
        mptr = (w + 1) % N;
        pv[w] = 1'b0;
      end
      tick;
      check("rnd_gnt", 32'(gnt), 32'(eg));
      check("rnd_pins", 32'({ram_we, ram_read, ram_clr}), 32'({ewe, erd, eclr}));
      if (w >= 0) check("rnd_addr", 32'(ram_addr), ea);
      check_rd(t);
    end
    req = '0;
    for (int t = 400; t < 404; t++) begin
      tick;
      check_rd(t);
    end
    check("rnd_rd_drained", rq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/counter_ram_arbiter.md
Name: counter_ram_arbiter

Overview:
- Shares one counter RAM (2**BITS_DIRECT entries of SIZE_COUNTER bits) among NUM_REQ requesters using round-robin arbitration.
- Each request is an increment, read or clear. The block drives the RAM's write_enable / adress / count_read / count_reset pins and returns read data tagged with the requester ID.
- Also runs a sweep-clear (flush) sequence that zeroes every entry without pulsing the RAM's global reset.
- Sits between the event sources (e.g. predictor/statistics units) and the counter RAM.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- BITS_DIRECT, 6, RAM address width.
- SIZE_COUNTER, 4, counter width; must match the RAM.

Ports:
- clk  in  1  system clock, rising edge.
- gen_reset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester request, held high until granted.
- req_op  in  2*NUM_REQ  op per requester: 00 increment, 01 read, 10 clear, 11 reserved (treated as no-op, still granted).
- req_addr  in  BITS_DIRECT*NUM_REQ  address per requester.
- gnt  out  NUM_REQ  one-hot, one-cycle grant pulse.
- flush_start  in  1  single-cycle pulse that starts the sweep-clear.
- busy  out  1  high while the flush is in progress.
- rd_valid  out  1  read data valid.
- rd_id  out  $clog2(NUM_REQ)  requester that issued the read.
- rd_data  out  SIZE_COUNTER  counter value.
- ram_we  out  1  to RAM write_enable.
- ram_addr  out  BITS_DIRECT  to RAM adress.
- ram_read  out  1  to RAM count_read.
- ram_clr  out  1  to RAM count_reset.
- ram_dout  in  SIZE_COUNTER  from RAM count_out.

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer at requester 0, flush counter 0.
- All outputs are registered. At most one RAM operation per cycle.
- States:
  - IDLE: no command issued.
  - SERVE: a granted command is being issued.
  - FLUSH: sweep-clear in progress.
- Transitions:
  - flush_start has priority over req in the same cycle.
  - IDLE/SERVE -> FLUSH on flush_start.
  - IDLE -> SERVE while any req is high.
  - FLUSH -> IDLE after issuing the clear to address 2**BITS_DIRECT-1.
  - SERVE with no req -> IDLE.
- Arbitration:
  - At edge E0, the highest-priority active req starting at the pointer wins.
  - In the following cycle: gnt[i]=1, and ram_addr plus exactly one of ram_we/ram_read/ram_clr reflect the op. All three pins are 0 for the reserved op.
  - Pointer moves to i+1 mod NUM_REQ.
  - One grant per cycle, so back-to-back service is possible. A requester must drop or update req in the cycle gnt is seen.
- RAM acts at E1, one edge after the command cycle.
- Read latency:
  - rd_valid=1 with rd_id=i and rd_data=ram_dout in the cycle after E1, i.e. 2 cycles after the accepting edge E0.
  - rd_valid is a single-cycle pulse, with no backpressure.
- Ordering: RAM operations occur in grant order. A read granted after an increment to the same address returns the post-increment value. No bypass is needed because ops are serialized.
- Counter wrap: increments wrap modulo 2**SIZE_COUNTER (RAM behaviour). The arbiter does not saturate.
- Flush:
  - busy=1 from the cycle after flush_start through the cycle issuing the last clear.
  - ram_clr=1 with ram_addr=0,1,...,2**BITS_DIRECT-1, taking 2**BITS_DIRECT cycles.
  - No gnt during flush; requests wait. Arbitration resumes the cycle after busy falls.
  - flush_start while busy is ignored.
  - A read already in flight when the flush starts still returns its rd_valid.
- Reset mid-operation: gen_reset immediately clears the state, pointer, busy, gnt and rd_valid. Any in-flight read is dropped and produces no rd_valid.
- Multiple requests to the same address from different requesters are serialized by arbitration; no merging.

Test Plan:
- Reset, then req[2]=1 with op=increment, addr=5, held for 3 grants, followed by a read from req[0] at addr 5. Required: ram_we pulses 3 times at addr 5; rd_valid with rd_id=0 and rd_data=3 arrives 2 cycles after the read is accepted.
- All 4 req high continuously, all reads. Required: gnt sequence 0,1,2,3,0; each rd_id matches its grant, 2 cycles later.
- 17 increments to addr 63 from req[1], then a read. Required: rd_data=1 (wrap at 16).
- flush_start asserted in the same cycle as req[3]. Required: busy high for exactly 64 cycles, ram_clr covers addresses 0..63, gnt[3] fires the cycle after busy falls, and a subsequent read of any entry returns 0.
- Read granted, then gen_reset asserted before rd_valid. Required: no rd_valid; all outputs read 0 the cycle after reset asserts.
- req[1] with reserved op 11. Required: gnt[1] pulses; ram_we, ram_read and ram_clr all stay 0; no rd_valid.
